// File: rtl/writeback_control_if.sv
// writeback_control_if: request, memory-return and register-file write signals of the writeback stage.
interface writeback_control_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              wb_valid;
    logic              wb_ready;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] reg_in;
    logic [DATA_W-1:0] pc_in;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_in;
    logic [1:0]        ld_size;
    logic              ld_unsigned;
    logic [1:0]        byte_off;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] write_data;
    logic              wb_err;

    modport master (
        output wb_valid, wb_sel, rd_addr, reg_in, pc_in, mem_rvalid, mem_in,
               ld_size, ld_unsigned, byte_off,
        input  wb_ready, rf_we, rf_waddr, write_data, wb_err
    );

    modport slave (
        input  wb_valid, wb_sel, rd_addr, reg_in, pc_in, mem_rvalid, mem_in,
               ld_size, ld_unsigned, byte_off,
        output wb_ready, rf_we, rf_waddr, write_data, wb_err
    );
endinterface

// File: rtl/writeback_control.sv
// writeback_control: registered writeback select with memory-wait timeout and one-cycle rf write strobe.
// WB_LOAD_EXT_EN enables byte/half lane extraction with sign/zero extension of load data (DATA_W=32).
module writeback_control #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int PC_INC  = 4,
    parameter int TIMEOUT = 15
) (
    input logic                i_clk,
    input logic                i_rst_n,
    writeback_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_cnt;
    logic [REG_AW-1:0] r_rd, r_waddr, w_waddr;
    logic [DATA_W-1:0] r_wdata, w_wdata, w_mem_data;
    logic              r_rf_we, r_err;
    logic              w_accept, w_got_mem, w_timeout, w_wr_go;

    assign w_accept  = (r_state == IDLE) && bus.wb_valid;
    assign w_got_mem = (r_state == WAIT_MEM) && bus.mem_rvalid;
    assign w_timeout = (r_state == WAIT_MEM) && !bus.mem_rvalid && (r_cnt == 8'(TIMEOUT - 1));

    // Outputs only move on a real write so they hold through x0 targets and timeouts.
    assign w_wr_go = w_got_mem ? (r_rd != '0)
                   : w_accept && (bus.wb_sel == 2'b01 || bus.wb_sel == 2'b10) && (bus.rd_addr != '0);
    assign w_waddr = w_got_mem ? r_rd : bus.rd_addr;
    assign w_wdata = w_got_mem ? w_mem_data
                   : (bus.wb_sel == 2'b01) ? bus.reg_in : bus.pc_in + DATA_W'(PC_INC);

`ifdef WB_LOAD_EXT_EN
    logic [1:0]  r_ld_size, r_off;
    logic        r_ld_uns;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte     = bus.mem_in[{r_off, 3'b000} +: 8];
    assign w_half     = bus.mem_in[{r_off[1], 4'b0000} +: 16];
    assign w_mem_data = (r_ld_size == 2'b00) ? {{(DATA_W-8){w_byte[7] & ~r_ld_uns}}, w_byte}
                      : (r_ld_size == 2'b01) ? {{(DATA_W-16){w_half[15] & ~r_ld_uns}}, w_half}
                      : bus.mem_in;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_size <= '0;
            r_off     <= '0;
            r_ld_uns  <= 1'b0;
        end else if (w_accept) begin
            r_ld_size <= bus.ld_size;
            r_off     <= bus.byte_off;
            r_ld_uns  <= bus.ld_unsigned;
        end
    end
`else
    assign w_mem_data = bus.mem_in;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = !bus.wb_valid ? IDLE
                             : (bus.wb_sel == 2'b00) ? WAIT_MEM
                             : (bus.wb_sel == 2'b11) ? IDLE : WRITE;
            WAIT_MEM: w_next = bus.mem_rvalid ? WRITE : w_timeout ? IDLE : WAIT_MEM;
            WRITE:    w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_rd    <= '0;
            r_rf_we <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_rf_we <= w_wr_go;
            if (w_accept) begin
                r_rd  <= bus.rd_addr;
                r_cnt <= '0;
            end else if (r_state == WAIT_MEM) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_wr_go) begin
                r_waddr <= w_waddr;
                r_wdata <= w_wdata;
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign bus.wb_ready   = (r_state == IDLE);
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_waddr;
    assign bus.write_data = r_wdata;
    assign bus.wb_err     = r_err;
endmodule

// File: tb/tb_writeback_control.sv
// tb_writeback_control: table vectors, corner sequences and random transactions for writeback_control.
module tb_writeback_control;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic        err_model = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always #5 clk = ~clk;

    writeback_control_if #(.DATA_W(32), .REG_AW(5)) bus ();

    writeback_control #(.DATA_W(32), .REG_AW(5), .PC_INC(4), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] regv, pcv, memv;
        int          k;
        logic [1:0]  sz;
        logic        uns;
        logic [1:0]  off;
        logic        ew;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] regv, pcv, memv,
                       input int k, input logic [1:0] sz, input logic uns, input logic [1:0] off,
                       input logic ew, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.sel = sel; v.rd = rd; v.regv = regv; v.pcv = pcv; v.memv = memv; v.k = k;
        v.sz = sz; v.uns = uns; v.off = off; v.ew = ew; v.ed = ed; v.ee = ee;
        tbl.push_back(v);
    endtask

    // Reference load value from shifts and arithmetic sign adjustment.
    function automatic logic [31:0] load_val(input logic [31:0] memv, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] off);
        logic [31:0] v;
        v = memv;
`ifdef WB_LOAD_EXT_EN
        if (sz == 2'b00) begin
            v = (memv >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = (memv >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end
`endif
        return v;
    endfunction

    task automatic do_txn(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] regv, pcv, memv,
                          input int k, input logic [1:0] sz, input logic uns, input logic [1:0] off,
                          input logic ew, input logic [31:0] ed, input logic ee);
        int rdy_c, we_n, we_c, exp_rdy, exp_wc;
        logic [4:0] wa;
        logic [31:0] wd;
        logic mem_ok;
        mem_ok  = (k <= TIMEOUT);
        exp_rdy = (sel == 2'b11) ? 1 : (sel == 2'b00) ? (mem_ok ? k + 2 : TIMEOUT + 1) : 2;
        exp_wc  = (sel == 2'b00) ? k + 1 : 1;
        @(negedge clk);
        check("ready_before_accept", bus.wb_ready, 1'b1);
        bus.wb_valid = 1'b1; bus.wb_sel = sel; bus.rd_addr = rd; bus.reg_in = regv; bus.pc_in = pcv;
        bus.ld_size = sz; bus.ld_unsigned = uns; bus.byte_off = off;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        bus.wb_sel = 2'($urandom); bus.rd_addr = 5'($urandom); bus.reg_in = $urandom; bus.pc_in = $urandom;
        rdy_c = 0; we_n = 0; we_c = 0; wa = '0; wd = '0;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            bus.mem_rvalid = (sel == 2'b00) && (c == k);
            bus.mem_in = (c == k) ? memv : $urandom;
            if (bus.rf_we) begin we_n++; we_c = c; wa = bus.rf_waddr; wd = bus.write_data; end
            if (bus.wb_ready && rdy_c == 0) rdy_c = c;
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
        if (ew) begin last_addr = rd; last_data = ed; end
        check("we_count", 32'(we_n), ew ? 32'd1 : 32'd0);
        if (ew) begin
            check("we_cycle", 32'(we_c), 32'(exp_wc));
            check("waddr", 32'(wa), 32'(rd));
            check("wdata", wd, ed);
        end
        check("ready_return", 32'(rdy_c), 32'(exp_rdy));
        check("wb_err", bus.wb_err, ee);
        check("hold_addr", 32'(bus.rf_waddr), 32'(last_addr));
        check("hold_data", bus.write_data, last_data);
        err_model = ee;
    endtask

    task automatic rand_txn();
        logic [1:0] sel, sz, off;
        logic [4:0] rd;
        logic [31:0] regv, pcv, memv, ed;
        logic uns, ew;
        int k;
        sel = 2'($urandom); sz = 2'($urandom); off = 2'($urandom); uns = 1'($urandom);
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        regv = $urandom; pcv = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom; memv = $urandom;
        k = $urandom_range(1, TIMEOUT + 2);
        ew = (rd != 0) && (sel == 2'b01 || sel == 2'b10 || (sel == 2'b00 && k <= TIMEOUT));
        ed = (sel == 2'b01) ? regv : (sel == 2'b10) ? pcv + 32'd4 : load_val(memv, sz, uns, off);
        do_txn(sel, rd, regv, pcv, memv, k, sz, uns, off, ew, ed,
               err_model | (sel == 2'b00 && k > TIMEOUT));
    endtask

    initial begin
        bus.wb_valid = 1'b0; bus.wb_sel = '0; bus.rd_addr = '0; bus.reg_in = '0; bus.pc_in = '0;
        bus.mem_rvalid = 1'b0; bus.mem_in = '0; bus.ld_size = '0; bus.ld_unsigned = 1'b0; bus.byte_off = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_we", bus.rf_we, 1'b0);
        check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_wdata", bus.write_data, 32'd0);
        check("rst_err", bus.wb_err, 1'b0);
        check("rst_ready", bus.wb_ready, 1'b1);
        @(negedge clk) rst_n = 1'b1;

        add(2'b01, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        add(2'b10, 5'd1, 32'h0, 32'hFFFFFFFC, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b1, 32'h00000000, 1'b0);
        add(2'b01, 5'd0, 32'h11111111, 32'h0, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        add(2'b00, 5'd3, 32'h0, 32'h0, 32'h12345678, 3, 2'b10, 1'b0, 2'd0, 1'b1, 32'h12345678, 1'b0);
        add(2'b11, 5'd9, 32'hAAAA5555, 32'h0, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        add(2'b00, 5'd4, 32'h0, 32'h0, 32'hCAFEF00D, TIMEOUT, 2'b10, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0);
        add(2'b00, 5'd0, 32'h0, 32'h0, 32'h0BADF00D, 2, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0);
        add(2'b10, 5'd31, 32'h0, 32'h00001000, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b1, 32'h00001004, 1'b0);
`ifdef WB_LOAD_EXT_EN
        add(2'b00, 5'd6, 32'h0, 32'h0, 32'h80FF7F01, 1, 2'b00, 1'b0, 2'd2, 1'b1, 32'hFFFFFFFF, 1'b0);
        add(2'b00, 5'd6, 32'h0, 32'h0, 32'h80FF7F01, 2, 2'b01, 1'b1, 2'd2, 1'b1, 32'h000080FF, 1'b0);
        add(2'b00, 5'd6, 32'h0, 32'h0, 32'h80FF7F01, 1, 2'b00, 1'b1, 2'd1, 1'b1, 32'h0000007F, 1'b0);
        add(2'b00, 5'd7, 32'h0, 32'h0, 32'h80FF7F01, 1, 2'b01, 1'b0, 2'd2, 1'b1, 32'hFFFF80FF, 1'b0);
        add(2'b00, 5'd7, 32'h0, 32'h0, 32'h80FF7F01, 1, 2'b11, 1'b1, 2'd3, 1'b1, 32'h80FF7F01, 1'b0);
`endif
        add(2'b00, 5'd2, 32'h0, 32'h0, 32'h77777777, TIMEOUT + 2, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
        add(2'b01, 5'd8, 32'h00005A5A, 32'h0, 32'h0, 1, 2'b10, 1'b0, 2'd0, 1'b1, 32'h00005A5A, 1'b1);
        foreach (tbl[i])
            do_txn(tbl[i].sel, tbl[i].rd, tbl[i].regv, tbl[i].pcv, tbl[i].memv, tbl[i].k,
                   tbl[i].sz, tbl[i].uns, tbl[i].off, tbl[i].ew, tbl[i].ed, tbl[i].ee);

        for (int n = 0; n < 60; n++) rand_txn();

        // Reset while waiting on memory: request dropped, sticky error cleared.
        @(negedge clk);
        bus.wb_valid = 1'b1; bus.wb_sel = 2'b00; bus.rd_addr = 5'd7;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_ready", bus.wb_ready, 1'b1);
        check("midrst_rf_we", bus.rf_we, 1'b0);
        check("midrst_err", bus.wb_err, 1'b0);
        check("midrst_wdata", bus.write_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        err_model = 1'b0; last_addr = '0; last_data = '0;
        @(negedge clk);
        bus.mem_rvalid = 1'b1; bus.mem_in = 32'h55555555;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("idle_rvalid_ignored", bus.rf_we, 1'b0);

        for (int n = 0; n < 30; n++) rand_txn();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_control.md
# writeback_control

Registered, parametrised writeback stage that picks the register-file write value from memory load data, the ALU/register result, or the link address (PC + PC_INC). It replaces the purely combinational writeback mux that sits between the execute/memory stage and the register file. It accepts one writeback request at a time over a valid/ready handshake and waits for variable-latency memory read data with a bounded timeout. It drives a single-cycle register-file write strobe.

## Interface
- DATA_W, 32: datapath width (write data, reg_in, pc_in, mem_in).
- REG_AW, 5: register address width.
- PC_INC, 4: constant added to pc_in for link writeback.
- TIMEOUT, 15: max cycles to wait for mem_rvalid; range 1..255.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  request valid.
- wb_ready  out  1  stage can accept (combinational, = state IDLE).
- wb_sel  in  2  source: 00 memory, 01 reg_in, 10 pc_in+PC_INC, 11 no write.
- rd_addr  in  REG_AW  destination register.
- reg_in  in  DATA_W  ALU/register result.
- pc_in  in  DATA_W  PC of the instruction.
- mem_rvalid  in  1  memory read data valid, 1-cycle pulse.
- mem_in  in  DATA_W  memory read data, sampled when mem_rvalid=1.
- ld_size  in  2  00 byte, 01 half, 10 word (used only with WB_LOAD_EXT_EN).
- ld_unsigned  in  1  zero-extend when 1 (WB_LOAD_EXT_EN only).
- byte_off  in  2  byte address offset of load (WB_LOAD_EXT_EN only).
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  REG_AW  write address, registered.
- write_data  out  DATA_W  write value, registered.
- wb_err  out  1  sticky memory-timeout flag; cleared only by reset.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- IDLE: wb_ready=1. Accept on wb_valid=1; capture rd_addr, wb_sel, ld_size, ld_unsigned and byte_off.
  - sel 01: capture reg_in, go to WRITE.
  - sel 10: capture pc_in+PC_INC (mod 2^DATA_W, carry dropped), go to WRITE.
  - sel 00: clear the timeout counter, go to WAIT_MEM.
  - sel 11: request consumed, no write, stay in IDLE.
- In IDLE, mem_rvalid is ignored.
- WAIT_MEM: wb_ready=0.
  - mem_rvalid=1: capture mem_in (after extension if enabled), go to WRITE.
  - Otherwise the counter increments. When it reaches TIMEOUT without data, set wb_err, go to IDLE, no write.
  - mem_rvalid on the same cycle the counter reaches TIMEOUT: the data wins, no error.
- WRITE: rf_we=1 for exactly one cycle with the captured rf_waddr/write_data, then go to IDLE.
  - rd_addr=0: rf_we stays 0 (x0 is never written), but the state sequence is unchanged.
- Async reset mid-operation: the pending request is dropped and the FSM returns to IDLE.

## Timing
- Reset values: rf_we=0, rf_waddr=0, write_data=0, wb_err=0, state IDLE (wb_ready=1).
- reg/pc source: accepted at edge N, rf_we=1 during cycle N+1, wb_ready=1 again in cycle N+2.
- Memory source: mem_rvalid sampled at edge M, rf_we=1 during cycle M+1.
- Throughput: one write per 2 cycles for reg/pc sources.
- write_data and rf_waddr hold their last values when rf_we=0.
- Timeout: with no mem_rvalid, wb_err rises TIMEOUT cycles after the acceptance edge.

## Configuration
- WB_LOAD_EXT_EN defined (requires DATA_W=32):
  - Memory data is lane-extracted by byte_off: byte uses mem_in[8*off+7:8*off]; half uses mem_in[16*off[1]+15:16*off[1]].
  - The extracted value is sign-extended, or zero-extended when ld_unsigned=1.
  - Word passes through unchanged.
  - ld_size=11 is treated as word.
- Not defined: mem_in is written unmodified; ld_size, ld_unsigned and byte_off are ignored. The ports remain present so the interface is stable.

## Test plan
- Reset: hold rst_n=0 -> rf_we=0, write_data=0, wb_err=0, wb_ready=1.
- sel=01, reg_in=0xDEADBEEF, rd=5 -> next cycle rf_we=1, rf_waddr=5, write_data=0xDEADBEEF; wb_ready=0 in that cycle.
- sel=10, pc_in=0xFFFFFFFC, rd=1 -> write_data=0x00000000 (wrap); then sel=01 with rd=0 -> rf_we stays 0.
- sel=00, rd=3, mem_rvalid after 3 cycles with mem_in=0x12345678 -> rf_we=1 one cycle after rvalid, write_data=0x12345678; wb_ready=0 throughout the wait.
- sel=00, no mem_rvalid, TIMEOUT=15 -> wb_err=1 after 15 cycles, no rf_we, wb_ready=1 again. A later mem_rvalid is ignored, and wb_err stays 1 until reset.
- WB_LOAD_EXT_EN: mem_in=0x80FF7F01, byte, off=2, signed -> 0xFFFFFFFF; half, off=2, unsigned -> 0x000080FF; byte, off=1, unsigned -> 0x0000007F.
